axi_rd_arbiter2: RTL and testbench

Two-master AXI4 read-channel arbiter that shares the single read port of the ThresholdCutter window RAM. Master 0 is the debug AXI reader; master 1 is the downstream feature/classifier reader. The block grants one whole burst at a time, registers the address channel toward the RAM, and routes the read-data channel back to the granted master. It also counts beats and flags bursts whose `rlast` does not match `arlen`.

---
 rtl/axi_rd_arbiter2_if.sv | 30 +++
 rtl/axi_rd_arbiter2.sv | 156 +++++++++++++++
 tb/tb_axi_rd_arbiter2.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arbiter2_if.sv
// rtl/axi_rd_arbiter2_if.sv - AXI4 read-only channel bundle (AR + R) with master/slave views
interface axi_rd_arbiter2_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
) ();
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter2.sv
// rtl/axi_rd_arbiter2.sv - two-master AXI4 read arbiter, burst-granular; AXI_ARB_FIXED_PRIO_EN selects fixed m0 priority
module axi_rd_arbiter2 #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axi_rd_arbiter2_if.slave       m0_axi,
    axi_rd_arbiter2_if.slave       m1_axi,
    axi_rd_arbiter2_if.master      s_axi,
    output logic                   grant,
    output logic                   busy,
    output logic                   len_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                state_q, state_d;
    logic                  grant_q;
    logic                  len_err_q;
    logic [7:0]            len_q;
    logic [8:0]            beat_cnt_q;
    logic [ID_WIDTH-1:0]   arid_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]            arlen_q;
    logic [2:0]            arsize_q;
    logic [1:0]            arburst_q;

    logic                  req_any;
    logic                  win;
    logic                  accept;
    logic                  arready0, arready1;
    logic                  rready_int;
    logic                  beat;
    logic                  bad_beat;
    logic [ID_WIDTH-1:0]   sel_arid;
    logic [ADDR_WIDTH-1:0] sel_araddr;
    logic [7:0]            sel_arlen;
    logic [2:0]            sel_arsize;
    logic [1:0]            sel_arburst;

    assign req_any = m0_axi.arvalid | m1_axi.arvalid;

`ifdef AXI_ARB_FIXED_PRIO_EN
    // Debug reader takes every tie; m1 only wins when m0 is silent.
    assign win = m1_axi.arvalid & ~m0_axi.arvalid;
`else
    logic rr_q;

    assign win = (m0_axi.arvalid & m1_axi.arvalid) ? rr_q : m1_axi.arvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else if (beat && s_axi.rlast) begin
            rr_q <= ~grant_q;
        end
    end
`endif

    always_comb begin
        sel_arid    = win ? m1_axi.arid    : m0_axi.arid;
        sel_araddr  = win ? m1_axi.araddr  : m0_axi.araddr;
        sel_arlen   = win ? m1_axi.arlen   : m0_axi.arlen;
        sel_arsize  = win ? m1_axi.arsize  : m0_axi.arsize;
        sel_arburst = win ? m1_axi.arburst : m0_axi.arburst;
    end

    assign rready_int = (state_q == DATA) & (grant_q ? m1_axi.rready : m0_axi.rready);
    assign beat       = (state_q == DATA) & s_axi.rvalid & rready_int;
    // A short burst is caught on rlast; a runaway one on every beat past the expected count.
    assign bad_beat   = s_axi.rlast ? (beat_cnt_q != {1'b0, len_q})
                                    : (beat_cnt_q >  {1'b0, len_q});

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        arready0 = 1'b0;
        arready1 = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    accept   = 1'b1;
                    arready0 = ~win;
                    arready1 = win;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                if (s_axi.arready) state_d = DATA;
            end
            DATA: begin
                if (beat && s_axi.rlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            len_err_q  <= 1'b0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            arid_q     <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
            arburst_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                arid_q     <= sel_arid;
                araddr_q   <= sel_araddr;
                arlen_q    <= sel_arlen;
                arsize_q   <= sel_arsize;
                arburst_q  <= sel_arburst;
                len_q      <= sel_arlen;
                grant_q    <= win;
                beat_cnt_q <= '0;
            end
            if (beat) begin
                if (beat_cnt_q != 9'h1ff) beat_cnt_q <= beat_cnt_q + 9'd1;
                if (bad_beat) len_err_q <= 1'b1;
            end
        end
    end

    assign s_axi.arid    = arid_q;
    assign s_axi.araddr  = araddr_q;
    assign s_axi.arlen   = arlen_q;
    assign s_axi.arsize  = arsize_q;
    assign s_axi.arburst = arburst_q;
    assign s_axi.arvalid = (state_q == ADDR);
    assign s_axi.rready  = rready_int;

    assign m0_axi.arready = arready0;
    assign m1_axi.arready = arready1;

    // Read payload fans out to both masters; only rvalid is steered by grant.
    assign m0_axi.rid    = s_axi.rid;
    assign m0_axi.rdata  = s_axi.rdata;
    assign m0_axi.rresp  = s_axi.rresp;
    assign m0_axi.rlast  = s_axi.rlast;
    assign m0_axi.rvalid = (state_q == DATA) & s_axi.rvalid & ~grant_q;
    assign m1_axi.rid    = s_axi.rid;
    assign m1_axi.rdata  = s_axi.rdata;
    assign m1_axi.rresp  = s_axi.rresp;
    assign m1_axi.rlast  = s_axi.rlast;
    assign m1_axi.rvalid = (state_q == DATA) & s_axi.rvalid & grant_q;

    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);
    assign len_err = len_err_q;
endmodule

// File: tb/tb_axi_rd_arbiter2.sv
// tb/tb_axi_rd_arbiter2.sv - directed scoreboard bench for axi_rd_arbiter2
module tb_axi_rd_arbiter2;
    logic clk;
    logic rst_n;
    logic grant;
    logic busy;
    logic len_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0]   id;
        logic [255:0] data;
        logic [1:0]   resp;
        logic         last;
    } beat_t;

    beat_t exp_q[$];

    axi_rd_arbiter2_if m0_if ();
    axi_rd_arbiter2_if m1_if ();
    axi_rd_arbiter2_if s_if ();

    axi_rd_arbiter2 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m0_axi  (m0_if),
        .m1_axi  (m1_if),
        .s_axi   (s_if),
        .grant   (grant),
        .busy    (busy),
        .len_err (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input int k, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        if (k == 0) begin
            m0_if.arid = id; m0_if.araddr = addr; m0_if.arlen = len;
            m0_if.arsize = 3'd5; m0_if.arburst = 2'd1; m0_if.arvalid = 1'b1;
        end else begin
            m1_if.arid = id; m1_if.araddr = addr; m1_if.arlen = len;
            m1_if.arsize = 3'd5; m1_if.arburst = 2'd1; m1_if.arvalid = 1'b1;
        end
    endtask

    // Entered at posedge+1 in IDLE with the request(s) already driven; leaves at posedge+1 in DATA.
    task automatic accept(input int k, input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input int ar_wait);
        #4;
        check("arready_winner", (k == 0) ? m0_if.arready : m1_if.arready, 1'b1);
        check("arready_loser",  (k == 0) ? m1_if.arready : m0_if.arready, 1'b0);
        check("s_arvalid_pre",  s_if.arvalid, 1'b0);
        tick();
        if (k == 0) m0_if.arvalid = 1'b0; else m1_if.arvalid = 1'b0;
        for (int w = 0; w <= ar_wait; w++) begin
            s_if.arready = (w == ar_wait);
            #4;
            check("s_arvalid",  s_if.arvalid, 1'b1);
            check("s_araddr",   s_if.araddr, addr);
            check("s_arlen",    s_if.arlen, len);
            check("s_arid",     s_if.arid, id);
            check("s_arsize",   s_if.arsize, 3'd5);
            check("grant",      grant, k[0]);
            check("busy",       busy, 1'b1);
            check("arready_ns", {m0_if.arready, m1_if.arready}, 2'b00);
            tick();
        end
        s_if.arready = 1'b0;
    endtask

    task automatic run_burst(input int k, input logic [3:0] id, input int nbeats,
                             input int last_at, input bit toggle);
        logic   rdy;
        logic   kvalid;
        beat_t  b;
        beat_t  exp;
        int     guard;
        bit     done;
        rdy = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            b.id   = id;
            b.data = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
            b.resp = 2'($urandom_range(0, 3));
            b.last = (i == last_at);
            s_if.rvalid = 1'b1;
            s_if.rid    = b.id;
            s_if.rdata  = b.data;
            s_if.rresp  = b.resp;
            s_if.rlast  = b.last;
            exp_q.push_back(b);
            done  = 1'b0;
            guard = 0;
            while (!done && guard < 20) begin
                if (k == 0) begin m0_if.rready = rdy; m1_if.rready = ~rdy; end
                else        begin m1_if.rready = rdy; m0_if.rready = ~rdy; end
                #4;
                kvalid = (k == 0) ? m0_if.rvalid : m1_if.rvalid;
                check("rready_mirror", s_if.rready, rdy);
                check("rvalid_granted", kvalid, 1'b1);
                check("rvalid_other", (k == 0) ? m1_if.rvalid : m0_if.rvalid, 1'b0);
                check("arready_busy", {m0_if.arready, m1_if.arready}, 2'b00);
                if (kvalid && rdy) begin
                    exp = exp_q.pop_front();
                    check("beat_data", (k == 0) ? m0_if.rdata : m1_if.rdata, exp.data);
                    check("beat_id",   (k == 0) ? m0_if.rid   : m1_if.rid,   exp.id);
                    check("beat_resp", (k == 0) ? m0_if.rresp : m1_if.rresp, exp.resp);
                    check("beat_last", (k == 0) ? m0_if.rlast : m1_if.rlast, exp.last);
                    done = 1'b1;
                end
                tick();
                if (toggle) rdy = ~rdy;
                guard++;
            end
            check("beat_timeout", done, 1'b1);
        end
        s_if.rvalid = 1'b0;
        s_if.rlast  = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_s_arvalid", s_if.arvalid, 1'b0);
        check("rst_s_araddr",  s_if.araddr, 32'h0);
        check("rst_s_arlen",   s_if.arlen, 8'h0);
        check("rst_s_arid",    s_if.arid, 4'h0);
        check("rst_arready",   {m0_if.arready, m1_if.arready}, 2'b00);
        check("rst_rvalid",    {m0_if.rvalid, m1_if.rvalid}, 2'b00);
        check("rst_s_rready",  s_if.rready, 1'b0);
        check("rst_grant",     grant, 1'b0);
        check("rst_busy",      busy, 1'b0);
        check("rst_len_err",   len_err, 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_if.arvalid = 1'b0; m0_if.arid = '0; m0_if.araddr = '0; m0_if.arlen = '0;
        m0_if.arsize = '0; m0_if.arburst = '0; m0_if.rready = 1'b0;
        m1_if.arvalid = 1'b0; m1_if.arid = '0; m1_if.araddr = '0; m1_if.arlen = '0;
        m1_if.arsize = '0; m1_if.arburst = '0; m1_if.rready = 1'b0;
        s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rid = '0;
        s_if.rdata = '0; s_if.rresp = '0; s_if.rlast = 1'b0;

        tick();
        check_reset_outputs();
        tick();
        rst_n = 1'b1;

        // Single m0 burst of 4 beats.
        request(0, 4'h5, 32'h40, 8'd3);
        accept(0, 4'h5, 32'h40, 8'd3, 0);
        run_burst(0, 4'h5, 4, 3, 1'b0);
        check("t1_len_err", len_err, 1'b0);
        check("t1_busy", busy, 1'b0);

        // Simultaneous requests straight after reset; m0 re-requests after its burst.
        pulse_reset();
        request(0, 4'h1, 32'h100, 8'd1);
        request(1, 4'h2, 32'h200, 8'd1);
        accept(0, 4'h1, 32'h100, 8'd1, 0);
        run_burst(0, 4'h1, 2, 1, 1'b0);
        request(0, 4'h3, 32'h300, 8'd1);
`ifdef AXI_ARB_FIXED_PRIO_EN
        accept(0, 4'h3, 32'h300, 8'd1, 0);
        run_burst(0, 4'h3, 2, 1, 1'b0);
        accept(1, 4'h2, 32'h200, 8'd1, 0);
        run_burst(1, 4'h2, 2, 1, 1'b0);
`else
        accept(1, 4'h2, 32'h200, 8'd1, 0);
        run_burst(1, 4'h2, 2, 1, 1'b0);
        accept(0, 4'h3, 32'h300, 8'd1, 0);
        run_burst(0, 4'h3, 2, 1, 1'b0);
`endif
        check("t2_len_err", len_err, 1'b0);

        // m1 8-beat burst with rready toggling; RAM stalls the address two cycles.
        request(1, 4'h9, 32'h1000, 8'd7);
        accept(1, 4'h9, 32'h1000, 8'd7, 2);
        run_burst(1, 4'h9, 8, 7, 1'b1);
        check("t3_len_err", len_err, 1'b0);
        check("t3_busy", busy, 1'b0);

        // rlast arrives on beat 2 of a 4-beat burst; the flag must stick.
        request(0, 4'h6, 32'h80, 8'd3);
        accept(0, 4'h6, 32'h80, 8'd3, 0);
        run_burst(0, 4'h6, 2, 1, 1'b0);
        check("t4_len_err", len_err, 1'b1);
        check("t4_busy", busy, 1'b0);
        request(1, 4'h7, 32'hC0, 8'd0);
        accept(1, 4'h7, 32'hC0, 8'd0, 0);
        run_burst(1, 4'h7, 1, 0, 1'b0);
        check("t4_len_err_sticky", len_err, 1'b1);

        // Reset after 2 of 4 beats, then a single-beat m1 burst.
        request(0, 4'hA, 32'h400, 8'd3);
        accept(0, 4'hA, 32'h400, 8'd3, 0);
        run_burst(0, 4'hA, 2, 99, 1'b0);
        check("t5_busy_mid", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        tick();
        rst_n = 1'b1;
        request(1, 4'h3, 32'h20, 8'd0);
        accept(1, 4'h3, 32'h20, 8'd0, 0);
        run_burst(1, 4'h3, 1, 0, 1'b0);
        check("t5_len_err", len_err, 1'b0);
        check("t5_busy", busy, 1'b0);

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
